gpio_wb_arbiter: RTL and testbench
==================================

Name: gpio_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares a single 8-bit GPIO Wishbone slave between requesters, for example the CPU data bus and a debug/boot master.
- Grants the slave one master at a time using round-robin priority.
- Muxes address, data and write-enable to the slave, and routes the slave ack back to the granted master only.
- Bounds grant hold time with a per-grant transfer limit and, optionally, a slave timeout.

Parameters:
- wb_adr_width, 4, address width shared by masters and slave
- wb_dat_width, 8, data width
- max_burst, 4, acks allowed per grant before forced release when the other master is requesting (1..255)
- timeout_cycles, 16, cycles of stb without ack before abort; used only with the optional feature (2..255)

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- m0_adr_i  in  wb_adr_width  master 0 address
- m0_dat_i  in  wb_dat_width  master 0 write data
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle
- m0_stb_i  in  1  master 0 strobe
- m0_ack_o  out  1  master 0 ack
- m0_err_o  out  1  master 0 error
- m0_dat_o  out  wb_dat_width  master 0 read data
- m1_*  same set as m0_*, for master 1
- s_adr_o  out  wb_adr_width  slave address
- s_dat_o  out  wb_dat_width  slave write data
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_ack_i  in  1  slave ack
- s_dat_i  in  wb_dat_width  slave read data

Behaviour:
- Clocking/reset: single clock wb_clk; reset wb_rst is synchronous and active-high.
- Reset state:
  - state=IDLE, last_grant=1 (master 0 wins first), burst_cnt=0, to_cnt=0.
  - All s_* outputs are 0; all m*_ack_o and m*_err_o are 0.
- Reset mid-transfer aborts it silently: no ack, no err.
- States: IDLE, GNT0, GNT1 (registered).
- IDLE:
  - Only m0_cyc_i high -> GNT0. Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master != last_grant.
  - Arbitration latency is 1 cycle; s_cyc_o stays 0 while in IDLE.
- Entering GNTx: last_grant<=x, burst_cnt<=0, to_cnt<=0.
- In GNTx, combinational outputs:
  - s_cyc_o=mx_cyc_i; s_stb_o=mx_stb_i&mx_cyc_i; s_adr_o/s_dat_o/s_we_o = master x signals.
  - mx_ack_o=s_ack_i; the other master's ack=0.
  - In IDLE, s_adr_o/s_dat_o/s_we_o=0.
- m0_dat_o and m1_dat_o are both driven from s_dat_i continuously; data is valid only with the own ack.
- On each s_ack_i in GNTx, burst_cnt increments, saturating at 255.
- GNTx -> IDLE when either condition holds:
  - (a) mx_cyc_i falls, or
  - (b) s_ack_i is asserted in the same cycle that burst_cnt+1 >= max_burst and the other master's cyc is high.
- Forced release only happens on an ack boundary and never cuts a transfer. The released master keeps cyc high and waits to be re-granted.
- Minimum one IDLE cycle between grants; there is no direct GNT0->GNT1 handover.
- The slave acks for exactly one cycle. Masters drop stb or present a new request after ack; the arbiter does not filter repeated acks.
- A grant to a master whose stb is low holds the slave idle until its cyc drops.

Optional Feature:
- Macro: GPIO_WB_ARB_TIMEOUT_EN.
- Enabled:
  - In GNTx, to_cnt increments on each cycle with s_stb_o=1 and s_ack_i=0; it clears on ack.
  - When to_cnt reaches timeout_cycles-1 without ack: mx_err_o=1 for that one cycle, s_stb_o and s_cyc_o are forced to 0 that cycle, and the next state is IDLE.
  - last_grant=x, so the other master wins next if it is requesting.
  - An ack in the same cycle as expiry wins: no err.
- Disabled: m0_err_o=m1_err_o=0 constantly; to_cnt logic is absent; a hung slave holds the grant until cyc drops.

Test Plan:
- Reset: hold wb_rst 2 cycles with both cyc high -> all s_* and m*_ack/err =0 during reset; s_cyc_o=1 with m0 signals on cycle 2 after release (GNT0).
- Single write: m1 writes adr 0 data 0xA5, others idle -> s_adr_o=0, s_dat_o=0xA5, s_we_o=1 one cycle after m1_cyc_i; m1_ack_o pulses once; m0_ack_o stays 0.
- Round-robin: m0 and m1 request simultaneously from reset, each doing one read of adr 1 and then dropping cyc -> order m0 then m1, with 1 IDLE cycle between; next simultaneous request goes to m0 (last_grant=1).
- Burst limit: max_burst=4, m0 performs 10 back-to-back writes while m1 holds cyc -> m0 gets 4 acks, IDLE, m1 served, then m0 resumes; m0 total acks=10, no transfer lost.
- Read routing: slave returns 0x3C for m0 read of adr 0 -> m0_dat_o=0x3C at m0_ack_o; m1_ack_o=0.
- Timeout (macro on, timeout_cycles=16): slave ack tied 0, m0 strobes -> m0_err_o=1 exactly at cycle 16 of strobe, s_stb_o=0 that cycle, state IDLE next. Macro off -> no err, grant held.

Source files
------------

// File: rtl/gpio_wb_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_wb_arbiter
//
// Purpose:
//   Round-robin arbiter that lets two Wishbone masters share one 8-bit GPIO
//   Wishbone slave. One master is granted at a time. The arbiter muxes
//   adr/dat/we/cyc/stb from the granted master to the slave. The slave ack
//   goes back to the granted master only. When the other master is waiting,
//   a grant is released after max_burst acks. There is always at least one
//   IDLE cycle between two grants.
//
// Optional feature (macro GPIO_WB_ARB_TIMEOUT_EN):
//   A strobe that is not acked within timeout_cycles cycles is aborted. The
//   granted master sees a one-cycle err, and the arbiter returns to IDLE.
//   When the macro is undefined, m0_err_o and m1_err_o are tied to 0.
//
// Ports:
//   wb_clk, wb_rst            clock, synchronous active-high reset
//   m0_* / m1_*               master-side Wishbone (adr, dat, we, cyc, stb in;
//                             ack, err, dat out)
//   s_*                       slave-side Wishbone (adr, dat, we, cyc, stb out;
//                             ack, dat in)
//   state_dbg                 current arbiter state (IDLE=0, GNT0=1, GNT1=2)
//
// Handshake:
//   A master owns a transfer while cyc & stb are high. The transfer completes
//   in the cycle where its ack is high. Read data on mX_dat_o is valid only
//   in that ack cycle. The slave acks for exactly one cycle per transfer.
// ---------------------------------------------------------------------------
module gpio_wb_arbiter #(
  parameter int wb_adr_width   = 4,
  parameter int wb_dat_width   = 8,
  parameter int max_burst      = 4,
  parameter int timeout_cycles = 16
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [wb_adr_width-1:0] m0_adr_i,
  input  logic [wb_dat_width-1:0] m0_dat_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [wb_dat_width-1:0] m0_dat_o,
  input  logic [wb_adr_width-1:0] m1_adr_i,
  input  logic [wb_dat_width-1:0] m1_dat_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [wb_dat_width-1:0] m1_dat_o,
  output logic [wb_adr_width-1:0] s_adr_o,
  output logic [wb_dat_width-1:0] s_dat_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  input  logic [wb_dat_width-1:0] s_dat_i,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [8:0] burst_lim = 9'(max_burst);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;   // 0: master 0 was granted last, 1: master 1
  logic [7:0] burst_cnt;

  // Signals of the granted master. They are all zero in IDLE and in reset.
  logic                    cur_cyc;
  logic                    cur_stb;
  logic                    cur_we;
  logic [wb_adr_width-1:0] cur_adr;
  logic [wb_dat_width-1:0] cur_dat;
  logic                    oth_cyc;
  logic                    req_stb;
  logic                    burst_hit;
  logic                    expire;

`ifdef GPIO_WB_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
`endif

  assign state_dbg = state;

  // Select the granted master. Reset forces everything to zero, so a
  // transfer that is in flight during reset is dropped without ack or err.
  always_comb begin
    cur_cyc = 1'b0;
    cur_stb = 1'b0;
    cur_we  = 1'b0;
    cur_adr = '0;
    cur_dat = '0;
    oth_cyc = 1'b0;
    if (!wb_rst) begin
      case (state)
        GNT0: begin
          cur_cyc = m0_cyc_i;
          cur_stb = m0_stb_i;
          cur_we  = m0_we_i;
          cur_adr = m0_adr_i;
          cur_dat = m0_dat_i;
          oth_cyc = m1_cyc_i;
        end
        GNT1: begin
          cur_cyc = m1_cyc_i;
          cur_stb = m1_stb_i;
          cur_we  = m1_we_i;
          cur_adr = m1_adr_i;
          cur_dat = m1_dat_i;
          oth_cyc = m0_cyc_i;
        end
        default: ;
      endcase
    end
  end

  assign req_stb = cur_cyc & cur_stb;

  // A forced release happens only on the ack that completes the
  // max_burst-th transfer, so a transfer is never cut in half.
  assign burst_hit = s_ack_i & oth_cyc & (({1'b0, burst_cnt} + 9'd1) >= burst_lim);

`ifdef GPIO_WB_ARB_TIMEOUT_EN
  // If an ack arrives in the expiry cycle, the ack takes priority.
  assign expire = req_stb & ~s_ack_i & (to_cnt == 8'(timeout_cycles - 1));
`else
  assign expire = 1'b0;
`endif

  // Slave-side and master-side outputs.
  always_comb begin
    s_cyc_o  = cur_cyc & ~expire;
    s_stb_o  = req_stb & ~expire;
    s_we_o   = cur_we;
    s_adr_o  = cur_adr;
    s_dat_o  = cur_dat;
    m0_ack_o = ~wb_rst & (state == GNT0) & s_ack_i;
    m1_ack_o = ~wb_rst & (state == GNT1) & s_ack_i;
    m0_err_o = ~wb_rst & (state == GNT0) & expire;
    m1_err_o = ~wb_rst & (state == GNT1) & expire;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_grant ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!cur_cyc || burst_hit || expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-grant counters. The counters are cleared while
  // in IDLE, so every grant starts from zero.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= 8'd0;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
      to_cnt     <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (state_nxt == GNT0) begin
          last_grant <= 1'b0;
        end else if (state_nxt == GNT1) begin
          last_grant <= 1'b1;
        end
        burst_cnt <= 8'd0;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
        to_cnt    <= 8'd0;
`endif
      end else begin
        if (s_ack_i && (burst_cnt != 8'hFF)) begin
          burst_cnt <= burst_cnt + 8'd1;
        end
`ifdef GPIO_WB_ARB_TIMEOUT_EN
        if (s_ack_i) begin
          to_cnt <= 8'd0;
        end else if (req_stb) begin
          to_cnt <= to_cnt + 8'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_wb_arbiter
//
// Directed bench for gpio_wb_arbiter with its default parameters
// (max_burst=4, timeout_cycles=16). A small registered slave model acks each
// strobe one cycle after it sees it, and never acks two cycles in a row.
// A monitor records acks and written data. Each expected value is written
// out by hand in the test that uses it.
// ---------------------------------------------------------------------------
module tb_gpio_wb_arbiter;

  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [3:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [7:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic       m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic       m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic       s_we_o, s_cyc_o, s_stb_o;
  logic       s_ack_i;
  logic [1:0] state_dbg;

  logic       slave_en;
  logic [7:0] slave_rdata;

  int tests  = 0;
  int failed = 0;

  // Monitor bookkeeping.
  int         cyc_cnt  = 0;
  int         m0_acks  = 0;
  int         m1_acks  = 0;
  int         both_ack = 0;
  int         ack_who[$];
  int         ack_cyc[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rd0, rd1;

  gpio_wb_arbiter dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_we_i  (m0_we_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m0_dat_o (m0_dat_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_we_i  (m1_we_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .m1_dat_o (m1_dat_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (s_ack_i),
    .s_dat_i  (s_dat_i),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- slave model ----------------
  assign s_dat_i = slave_rdata;

  always @(posedge wb_clk) begin
    if (wb_rst) s_ack_i <= 1'b0;
    else        s_ack_i <= slave_en & s_cyc_o & s_stb_o & ~s_ack_i;
  end

  // ---------------- monitor ----------------
  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      if (m0_ack_o && m1_ack_o) both_ack <= both_ack + 1;
      if (m0_ack_o) begin
        m0_acks <= m0_acks + 1;
        ack_who.push_back(0);
        ack_cyc.push_back(cyc_cnt);
      end
      if (m1_ack_o) begin
        m1_acks <= m1_acks + 1;
        ack_who.push_back(1);
        ack_cyc.push_back(cyc_cnt);
      end
      if (s_ack_i && s_we_o) got_q.push_back(s_dat_o);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] adr, input logic [7:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic do_reset();
    @(posedge wb_clk); #1;
    wb_rst = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
  endtask

  // Master m performs n back-to-back transfers. It keeps cyc and stb high
  // until its n-th ack, and the write data for transfer k is base+k.
  task automatic master_run(input int m, input int n, input logic we,
                            input logic [3:0] adr, input logic [7:0] base);
    int cnt   = 0;
    int guard = 0;
    @(posedge wb_clk); #1;
    drive(m, 1'b1, 1'b1, we, adr, base);
    while (cnt < n && guard < 300) begin
      @(negedge wb_clk);
      guard++;
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        cnt++;
        if (m == 0) rd0 = m0_dat_o; else rd1 = m1_dat_o;
        @(posedge wb_clk); #1;
        if (cnt < n) drive(m, 1'b1, 1'b1, we, adr, 8'(base + 8'(cnt)));
        else         drive(m, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      end
    end
    if (cnt < n) begin
      check($sformatf("m%0d_acks_in_budget", m), cnt, n);
      drive(m, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, b0, b1, errs, err_at;
    logic stb16, cyc17;

    wb_rst      = 1'b1;
    slave_en    = 1'b0;
    slave_rdata = 8'h00;
    drive(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h11);
    drive(1, 1'b1, 1'b1, 1'b1, 4'd7, 8'h22);

    // Reset, held 2 cycles with both masters requesting.
    repeat (2) begin
      @(negedge wb_clk);
      check("reset_outputs_zero",
            {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o},
            32'd0);
    end
    @(posedge wb_clk); #1 wb_rst = 1'b0;
    @(negedge wb_clk);
    check("post_reset_cycle1_idle", s_cyc_o, 1'b0);
    @(negedge wb_clk);
    check("post_reset_cycle2_gnt0", {s_cyc_o, s_stb_o, s_adr_o, s_dat_o}, {1'b1, 1'b1, 4'd3, 8'h11});
    @(posedge wb_clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    slave_en = 1'b1;
    repeat (3) @(posedge wb_clk);

    // Single write from m1.
    b0 = m0_acks; b1 = m1_acks;
    @(posedge wb_clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 4'd0, 8'hA5);
    @(negedge wb_clk);
    check("sw_arb_latency_idle", s_cyc_o, 1'b0);
    @(negedge wb_clk);
    check("sw_slave_bus", {s_cyc_o, s_we_o, s_adr_o, s_dat_o, m1_ack_o}, {1'b1, 1'b1, 4'd0, 8'hA5, 1'b0});
    @(negedge wb_clk);
    check("sw_ack_routing", {m1_ack_o, m0_ack_o}, 2'b10);
    @(posedge wb_clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    repeat (3) @(negedge wb_clk);
    check("sw_m1_ack_count", m1_acks - b1, 1);
    check("sw_m0_ack_count", m0_acks - b0, 0);

    // Round-robin after reset: m0 goes first, then m1.
    do_reset();
    repeat (2) @(posedge wb_clk);
    for (int r = 0; r < 2; r++) begin
      b = ack_who.size();
      fork
        master_run(0, 1, 1'b0, 4'd1, 8'd0);
        master_run(1, 1, 1'b0, 4'd1, 8'd0);
      join
      check($sformatf("rr%0d_ack_total", r), ack_who.size() - b, 2);
      if (ack_who.size() >= b + 2) begin
        check($sformatf("rr%0d_order", r), {ack_who[b][0], ack_who[b+1][0]}, 2'b01);
        // Ack, drop cyc, one IDLE cycle, grant, then ack: 4 cycles.
        check($sformatf("rr%0d_ack_gap", r), ack_cyc[b+1] - ack_cyc[b], 4);
      end
      repeat (2) @(posedge wb_clk);
    end

    // Burst limit: m0 does 10 writes while m1 holds cyc for a single write.
    b0 = m0_acks; b1 = m1_acks; b = got_q.size();
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h80, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    fork
      master_run(0, 10, 1'b1, 4'd2, 8'h10);
      master_run(1, 1, 1'b1, 4'd5, 8'h80);
    join
    repeat (2) @(negedge wb_clk);
    check("burst_m0_acks", m0_acks - b0, 10);
    check("burst_m1_acks", m1_acks - b1, 1);
    check("burst_write_total", got_q.size() - b, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < got_q.size())
        check($sformatf("burst_write_%0d", i), got_q[b+i], exp_q[i]);
    end

    // Read routing.
    slave_rdata = 8'h3C;
    rd0 = 8'h00;
    b1 = m1_acks;
    master_run(0, 1, 1'b0, 4'd0, 8'd0);
    repeat (2) @(negedge wb_clk);
    check("read_m0_data", rd0, 8'h3C);
    check("read_m1_no_ack", m1_acks - b1, 0);

    // Hung slave. m0 strobes, and k counts its strobe cycles.
    slave_en = 1'b0;
    errs = 0; err_at = 0; stb16 = 1'b0;
    @(posedge wb_clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
    @(negedge wb_clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge wb_clk);
      if (m0_err_o || m1_err_o) begin
        errs++;
        err_at = k;
      end
      if (k == 16) stb16 = s_stb_o;
    end
    @(negedge wb_clk);
    cyc17 = s_cyc_o;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
    check("to_err_pulses", errs, 1);
    check("to_err_cycle", err_at, 16);
    check("to_stb_forced_low", stb16, 1'b0);
    check("to_idle_after", cyc17, 1'b0);
`else
    check("to_no_err", errs, 0);
    check("to_grant_held_stb", stb16, 1'b1);
    check("to_grant_held_cyc", cyc17, 1'b1);
`endif

    // Reset in the middle of a transfer drops it silently.
    @(posedge wb_clk); #1 wb_rst = 1'b1;
    @(negedge wb_clk);
    check("midreset_silent", {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o}, 4'b0000);
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    slave_en = 1'b1;
    repeat (2) @(negedge wb_clk);

    check("never_both_acks", both_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time limit on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
